// File: rtl/scan_trig_gen_pkg.sv
// Shared types and constants for the scan-head trigger generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scan_pkg;

    // Default register widths as seen in the PCIe register bank
    localparam int DIV_W_DEF = 6;
    localparam int LOW_W_DEF = 10;
    localparam int PER_W_DEF = 16;
    localparam int CNT_W_DEF = 16;

    // Trigger line level while no pulse is being driven (line is active-low)
    localparam logic TRIG_IDLE = 1'b1;

    // Burst sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/scan_trig_gen_if.sv
// Register-bank / control bundle between the host side and the trigger generator.
// Latency: n/a (wires only).
// Backpressure: none; start edges arriving while a burst runs are dropped by the generator.
interface scan_trig_gen_if
    import scan_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int LOW_W = LOW_W_DEF,
    parameter int PER_W = PER_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    // Host-domain configuration (quasi-static, resynchronised inside the generator)
    logic [DIV_W-1:0] div_reg;
    logic [LOW_W-1:0] low_reg;
    logic [PER_W-1:0] period_reg;
    logic [CNT_W-1:0] count_reg;

    // Control levels
    logic             start;
    logic             abort;

    // Trigger line and status
    logic             trig_out;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [CNT_W-1:0] pulse_idx;

    // Host / register-bank side
    modport master (
        output div_reg, low_reg, period_reg, count_reg, start, abort,
        input  trig_out, busy, done, cfg_err, pulse_idx
    );

    // Trigger generator side
    modport slave (
        input  div_reg, low_reg, period_reg, count_reg, start, abort,
        output trig_out, busy, done, cfg_err, pulse_idx
    );

endinterface

// File: rtl/scan_trig_gen_cfg_sync_stable.sv
// Brings a quasi-static multi-bit config word into clk: two capture flops, then a hold register.
// Latency: a value stable at the input appears on o_dat 3 clk later.
// Backpressure: none; values that change between consecutive samples are never passed on.
module cfg_sync_stable #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);

    logic [WIDTH-1:0] r_d0;
    logic [WIDTH-1:0] r_d1;
    logic [WIDTH-1:0] r_d2;

    // Capture twice; only accept the word once two consecutive samples agree,
    // so a multi-bit word caught mid-update is never presented as a mixed value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d0 <= '0;
            r_d1 <= '0;
            r_d2 <= '0;
        end else begin
            r_d0 <= i_dat;
            r_d1 <= r_d0;
            if (r_d0 == r_d1) begin
                r_d2 <= r_d1;
            end
        end
    end

    assign o_dat = r_d2;

endmodule

// File: rtl/scan_trig_gen.sv
// Active-low scan-head trigger pulse train: width, period and count from a prescaled tick.
// Latency: trig_out falls 1 clk after the start edge; done/cfg_err are 1-clk pulses.
// Backpressure: none; start edges outside IDLE are ignored, abort always wins.
module scan_trig_gen
    import scan_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int LOW_W = LOW_W_DEF,
    parameter int PER_W = PER_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    scan_trig_gen_if.slave bus
);

    // Synchronised config (live values from the register bank)
    logic [DIV_W-1:0] w_div;
    logic [LOW_W-1:0] w_low;
    logic [PER_W-1:0] w_per;
    logic [CNT_W-1:0] w_cnt;
    logic [PER_W-1:0] w_low_x;

    // Shadowed config, frozen for the duration of a burst
    logic [DIV_W-1:0] r_div_sh;
    logic [LOW_W-1:0] r_low_sh;
    logic [PER_W-1:0] r_per_sh;
    logic [CNT_W-1:0] r_cnt_sh;
    logic [PER_W-1:0] w_low_sh_x;

    // Sequencer state and datapath
    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_start_q;
    logic [DIV_W-1:0] r_presc;
    logic [PER_W-1:0] r_phase;
    logic [PER_W-1:0] w_phase_inc;
    logic [CNT_W-1:0] r_idx;
    logic             r_cfg_err;

    logic             w_start_edge;
    logic             w_cfg_bad;
    logic             w_accept;
    logic             w_running;
    logic             w_tick;
    logic             w_low_end;
    logic             w_per_end;
    logic             w_cnt_reached;

    cfg_sync_stable #(.WIDTH(DIV_W)) u_sync_div (
        .clk   (clk),
        .rst_n (rst_n),
        .i_dat (bus.div_reg),
        .o_dat (w_div)
    );

    cfg_sync_stable #(.WIDTH(LOW_W)) u_sync_low (
        .clk   (clk),
        .rst_n (rst_n),
        .i_dat (bus.low_reg),
        .o_dat (w_low)
    );

    cfg_sync_stable #(.WIDTH(PER_W)) u_sync_per (
        .clk   (clk),
        .rst_n (rst_n),
        .i_dat (bus.period_reg),
        .o_dat (w_per)
    );

    cfg_sync_stable #(.WIDTH(CNT_W)) u_sync_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_dat (bus.count_reg),
        .o_dat (w_cnt)
    );

    // Low width is compared against PER_W-wide quantities; widen without sign.
    assign w_low_x    = PER_W'(w_low);
    assign w_low_sh_x = PER_W'(r_low_sh);

    // A pulse needs a non-zero low phase and some high time after it.
    assign w_cfg_bad    = (w_low == '0) || (w_per <= w_low_x);
    assign w_start_edge = bus.start & ~r_start_q;
    assign w_accept     = (r_state == ST_IDLE) && w_start_edge && !bus.abort && !w_cfg_bad;
    assign w_running    = (r_state == ST_LOW) || (r_state == ST_HIGH);

    // Phase advances once per prescaler wrap; ends are detected on the tick
    // that would make the phase reach the programmed limit.
    assign w_tick        = (r_presc == r_div_sh);
    assign w_phase_inc   = r_phase + 1'b1;
    assign w_low_end     = (r_state == ST_LOW)  && w_tick && (w_phase_inc == w_low_sh_x);
    assign w_per_end     = (r_state == ST_HIGH) && w_tick && (w_phase_inc == r_per_sh);
    assign w_cnt_reached = (r_cnt_sh != '0) && (r_idx == r_cnt_sh);

    // Previous start level for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_q <= 1'b0;
        end else begin
            r_start_q <= bus.start;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer next state; abort overrides every other transition
    always_comb begin
        w_state_nxt = r_state;
        if (bus.abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (w_low_end) begin
                        w_state_nxt = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (w_per_end) begin
                        w_state_nxt = w_cnt_reached ? ST_FIN : ST_LOW;
                    end
                end
                ST_FIN: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer outputs decoded from the registered state, so a reset
    // returns the trigger line to idle without waiting for a clock
    always_comb begin
        bus.trig_out = TRIG_IDLE;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (r_state)
            ST_LOW: begin
                bus.trig_out = ~TRIG_IDLE;
                bus.busy     = 1'b1;
            end
            ST_HIGH: begin
                bus.busy     = 1'b1;
            end
            ST_FIN: begin
                bus.done     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Shadow capture on acceptance; prescaler, phase and pulse count while running.
    // Abort freezes everything so pulse_idx keeps the count reached so far.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_sh <= '0;
            r_low_sh <= '0;
            r_per_sh <= '0;
            r_cnt_sh <= '0;
            r_presc  <= '0;
            r_phase  <= '0;
            r_idx    <= '0;
        end else if (w_accept) begin
            r_div_sh <= w_div;
            r_low_sh <= w_low;
            r_per_sh <= w_per;
            r_cnt_sh <= w_cnt;
            r_presc  <= '0;
            r_phase  <= '0;
            r_idx    <= '0;
        end else if (w_running && !bus.abort) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_phase <= w_per_end ? '0 : w_phase_inc;
            end
            if (w_low_end && (r_idx != '1)) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // One-cycle rejection pulse for a start edge seen with unusable config
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= (r_state == ST_IDLE) && w_start_edge && !bus.abort && w_cfg_bad;
        end
    end

    assign bus.cfg_err   = r_cfg_err;
    assign bus.pulse_idx = r_idx;

endmodule

// File: tb/tb_scan_trig_gen.sv
// Bench for scan_trig_gen: schedule-based reference model plus directed and random bursts.
// Latency: n/a.
// Backpressure: n/a.
module tb_scan_trig_gen;
    import scan_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    scan_trig_gen_if bus ();

    scan_trig_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A burst is a timetable: starting at cycle t0, offset o lies in pulse o/P at
    // position o%P (low while position < L); with a finite count the cycle at
    // offset count*P is the completion cycle.
    int   m_cyc  = 0;
    bit   m_run  = 0;
    bit   m_sprev = 0;
    int   m_t0 = 0, m_div = 0, m_low = 0, m_per = 0, m_cnt = 0;
    int   m_hold = 0;
    logic e_trig = 1'b1, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
    int   e_idx = 0;
    int   mc_c, mc_o, mc_p, mc_l, mc_np, mc_r;
    bit   mc_act, mc_edge;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_cyc = 0; m_run = 0; m_sprev = 0; m_hold = 0;
                e_trig = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_idx = 0;
            end else begin
                mc_c    = m_cyc;
                mc_act  = m_run;
                mc_edge = bus.start && !m_sprev;
                m_sprev = bus.start;
                m_cyc   = m_cyc + 1;
                e_err   = 1'b0;
                if (mc_act && m_cnt != 0 && (mc_c - m_t0) == m_cnt * m_per * (m_div + 1))
                    m_run = 0;
                if (bus.abort) begin
                    m_run = 0;
                end else if (!mc_act && mc_edge) begin
                    if (bus.low_reg == 0 || bus.period_reg <= bus.low_reg) begin
                        e_err = 1'b1;
                    end else begin
                        m_run = 1; m_t0 = m_cyc;
                        m_div = bus.div_reg; m_low = bus.low_reg;
                        m_per = bus.period_reg; m_cnt = bus.count_reg;
                    end
                end
                if (m_run) begin
                    mc_p = m_per * (m_div + 1);
                    mc_l = m_low * (m_div + 1);
                    mc_o = m_cyc - m_t0;
                    if (m_cnt != 0 && mc_o == m_cnt * mc_p) begin
                        e_trig = 1'b1; e_busy = 1'b0; e_done = 1'b1; e_idx = m_cnt;
                    end else begin
                        mc_np  = mc_o / mc_p;
                        mc_r   = mc_o % mc_p;
                        e_trig = (mc_r >= mc_l);
                        e_busy = 1'b1; e_done = 1'b0;
                        e_idx  = mc_np + ((mc_r >= mc_l) ? 1 : 0);
                        if (e_idx > 65535) e_idx = 65535;
                    end
                    m_hold = e_idx;
                end else begin
                    e_trig = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_idx = m_hold;
                end
            end
        end
    end

    // Every cycle, DUT outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("trig_out",  bus.trig_out,  e_trig);
            chk("busy",      bus.busy,      e_busy);
            chk("done",      bus.done,      e_done);
            chk("cfg_err",   bus.cfg_err,   e_err);
            chk("pulse_idx", bus.pulse_idx, e_idx);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_cfg(input int d, input int l, input int p, input int c);
        @(posedge clk); #1;
        bus.abort = 1'b1; bus.start = 1'b0;
        bus.div_reg = 6'(d); bus.low_reg = 10'(l);
        bus.period_reg = 16'(p); bus.count_reg = 16'(c);
        @(posedge clk); #1;
        bus.abort = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic raise_start(output int k);
        @(posedge clk); #1;
        bus.start = 1'b1;
        k = m_cyc;
    endtask

    task automatic wait_done(input int k, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 && at < 0) at = m_cyc - k;
        end
    endtask

    // ---------------- directed + random tests ----------------
    logic tr [0:23];
    logic dn [0:23];
    logic bs [0:23];
    int   id [0:23];
    int   k, at, lows, dcnt, bseen, n, d, l, p, c;
    bit   fin;

    initial begin
        bus.div_reg = '0; bus.low_reg = '0; bus.period_reg = '0; bus.count_reg = '0;
        bus.start = 1'b0; bus.abort = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_trig", bus.trig_out, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_idx",  bus.pulse_idx, 0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Two pulses: 3 low + 7 high each, done at k+21
        set_cfg(0, 3, 10, 2);
        raise_start(k);
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            tr[j] = bus.trig_out; dn[j] = bus.done; bs[j] = bus.busy; id[j] = bus.pulse_idx;
        end
        chk("t1_k_trig",   tr[0], 1);
        chk("t1_k1_trig",  tr[1], 0);
        chk("t1_k1_busy",  bs[1], 1);
        chk("t1_k3_trig",  tr[3], 0);
        chk("t1_k4_trig",  tr[4], 1);
        chk("t1_k4_idx",   id[4], 1);
        chk("t1_k10_trig", tr[10], 1);
        chk("t1_k11_trig", tr[11], 0);
        chk("t1_k13_trig", tr[13], 0);
        chk("t1_k14_trig", tr[14], 1);
        chk("t1_k20_done", dn[20], 0);
        chk("t1_k21_done", dn[21], 1);
        chk("t1_k21_busy", bs[21], 0);
        chk("t1_k21_idx",  id[21], 2);
        chk("t1_k23_busy", bs[23], 0);
        chk("t1_k23_idx",  id[23], 2);
        bus.start = 1'b0;

        // Prescaled: low 8 clk, period 20 clk, single done
        set_cfg(3, 2, 5, 1);
        raise_start(k);
        lows = 0; dcnt = 0; at = -1;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (bus.trig_out === 1'b0) lows++;
            if (bus.done === 1'b1) begin dcnt++; if (at < 0) at = m_cyc - k; end
        end
        chk("t2_low_clks", lows, 8);
        chk("t2_done_cnt", dcnt, 1);
        chk("t2_done_at",  at, 21);

        // Rejected configs: low == period, then low == 0
        for (int v = 0; v < 2; v++) begin
            set_cfg(0, (v == 0) ? 5 : 0, 5, 1);
            raise_start(k);
            @(negedge clk);
            @(negedge clk);
            chk("t3_cfg_err", bus.cfg_err, 1);
            chk("t3_busy",    bus.busy, 0);
            chk("t3_trig",    bus.trig_out, 1);
            @(negedge clk);
            chk("t3_err_clr", bus.cfg_err, 0);
        end

        // Continuous mode, 10 periods then abort
        set_cfg(0, 1, 4, 0);
        raise_start(k);
        lows = 0; dcnt = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (bus.trig_out === 1'b0) lows++;
            if (bus.done === 1'b1) dcnt++;
        end
        @(posedge clk); #1; bus.abort = 1'b1;
        @(negedge clk);
        if (bus.done === 1'b1) dcnt++;
        @(posedge clk); #1; bus.abort = 1'b0;
        @(negedge clk);
        if (bus.done === 1'b1) dcnt++;
        chk("t4_lows",  lows, 10);
        chk("t4_done",  dcnt, 0);
        chk("t4_busy",  bus.busy, 0);
        chk("t4_trig",  bus.trig_out, 1);
        chk("t4_idx",   bus.pulse_idx, 10);

        // Period change and extra start edge mid-burst
        set_cfg(0, 2, 6, 3);
        raise_start(k);
        repeat (4) @(negedge clk);
        @(posedge clk); #1; bus.period_reg = 16'd9; bus.start = 1'b0;
        @(posedge clk); #1; bus.start = 1'b1;
        fin = 0; at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 && at < 0) at = m_cyc - k;
        end
        chk("t5_done_at", at, 19);
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (3) @(posedge clk);
        raise_start(k);
        wait_done(k, 40, at);
        chk("t5_new_per", at, 28);
        bus.start = 1'b0;

        // Start and abort together from IDLE
        set_cfg(0, 2, 5, 1);
        @(posedge clk); #1; bus.start = 1'b1; bus.abort = 1'b1;
        bseen = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.trig_out !== 1'b1 || bus.cfg_err !== 1'b0) bseen++;
        end
        chk("t6_no_burst", bseen, 0);
        @(posedge clk); #1; bus.start = 1'b0; bus.abort = 1'b0;

        // Asynchronous reset while the line is low
        set_cfg(0, 20, 30, 1);
        raise_start(k);
        repeat (5) @(negedge clk);
        chk("t7_pre_trig", bus.trig_out, 0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t7_arst_trig", bus.trig_out, 1);
        chk("t7_arst_busy", bus.busy, 0);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;

        // Random bursts with random aborts and start toggles
        for (int it = 0; it < 30; it++) begin
            d = $urandom_range(0, 3);
            l = $urandom_range(0, 6);
            p = $urandom_range(0, 12);
            c = $urandom_range(0, 3);
            set_cfg(d, l, p, c);
            raise_start(k);
            n = 0; fin = 0;
            while (!fin) begin
                @(posedge clk); #1;
                n++;
                bus.abort = ($urandom_range(0, 99) < 2) || (c == 0 && n > 60);
                if ($urandom_range(0, 99) < 4) bus.start = ~bus.start;
                if (n > 3 && !m_run) fin = 1;
                if (n >= 400) begin
                    chk("rand_timeout_busy", bus.busy, 0);
                    fin = 1;
                end
            end
            bus.abort = 1'b0;
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
